csa_resolver: RTL

Carry-propagate resolution stage placed directly downstream of the carry-save adder. It accepts one carry-save pair per transaction: a carry word (already shifted left by one) and a partial-sum word. It resolves the pair into a single binary sum by iterating `S ← S ^ C`, `C ← (S & C) << 1`, one step per clock, until the carry word is zero. It returns the W-bit sum, the carry-out and the iteration count over a valid/ready handshake, so a small XOR/AND datapath replaces a full-width adder.

---
 rtl/csa_resolver.sv | 89 ++++++++
 1 files changed

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair into a binary sum with an iterative XOR/AND loop.
// A single step runs per clock, and the result is handed downstream over a
// valid/ready handshake.
module csa_resolver #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_c,
  input  logic [W-1:0]  in_s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_cout,
  output logic [CW-1:0] out_iters
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  c_q, c_d;
  logic          cout_q, cout_d;
  logic [CW-1:0] iters_q, iters_d;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      cout_q  <= 1'b0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      iters_q <= iters_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    c_d      = c_q;
    cout_d   = cout_q;
    iters_d  = iters_q;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      ITER: begin
        s_d     = s_q ^ c_q;
        // Bit W-1 of the generate term falls off the top; it is the carry-out.
        c_d     = {s_q[W-2:0] & c_q[W-2:0], 1'b0};
        cout_d  = cout_q | (s_q[W-1] & c_q[W-1]);
        iters_d = iters_q + CW'(1);
        if (c_d == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // Accepting in DONE overrides the retire-to-IDLE path for back-to-back flow.
    if (accept) begin
      s_d     = in_s;
      c_d     = in_c;
      cout_d  = 1'b0;
      iters_d = '0;
      state_d = (in_c == '0) ? DONE : ITER;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_sum   = s_q;
  assign out_cout  = cout_q;
  assign out_iters = iters_q;

endmodule
